// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: hazard inputs from the pipe, stall/flush controls back.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic             idex_memread_i;
  logic [4:0]       idex_rd_i;
  logic [4:0]       ifid_rs1_i;
  logic [4:0]       ifid_rs2_i;
  logic             exmem_branch_i;
  logic             exmem_memaccess_i;
  logic             mem_ack_i;
  logic             mem_req_o;
  logic             pc_stall_o;
  logic             ifid_stall_o;
  logic             idex_stall_o;
  logic             exmem_stall_o;
  logic             ifid_flush_o;
  logic             idex_flush_o;
  logic             exmem_flush_o;
  logic             timeout_o;
  logic [CNT_W-1:0] hazard_cnt_o;

  modport master (
    output idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i,
           exmem_branch_i, exmem_memaccess_i, mem_ack_i,
    input  mem_req_o, pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o, timeout_o, hazard_cnt_o
  );

  modport slave (
    input  idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i,
           exmem_branch_i, exmem_memaccess_i, mem_ack_i,
    output mem_req_o, pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o, timeout_o, hazard_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipe scheduler: load-use bubbles, branch flushes, memory-wait holds with timeout.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  hif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, ERR} state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t           state, nxt;
  logic [7:0]       wcnt, wcnt_nxt;
  logic [CNT_W-1:0] hcnt;
  logic             timeout_q;
  logic             mem_req, pc_st, ifid_st, idex_st, exmem_st;
  logic             ifid_fl, idex_fl, exmem_fl;
  logic             load_use;

  assign load_use = hif.idex_memread_i && (hif.idex_rd_i != 5'd0) &&
                    ((hif.idex_rd_i == hif.ifid_rs1_i) || (hif.idex_rd_i == hif.ifid_rs2_i));

  always_comb begin
    nxt      = state;
    wcnt_nxt = wcnt;
    mem_req  = 1'b0;
    pc_st    = 1'b0;
    ifid_st  = 1'b0;
    idex_st  = 1'b0;
    exmem_st = 1'b0;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    exmem_fl = 1'b0;
    case (state)
      RUN: begin
        mem_req = hif.exmem_memaccess_i;
        if (hif.exmem_memaccess_i && !hif.mem_ack_i) begin
          {pc_st, ifid_st, idex_st, exmem_st} = 4'hf;
          nxt      = MEM_WAIT;
          wcnt_nxt = 8'd1;
        end else if (hif.exmem_branch_i) begin
          {ifid_fl, idex_fl, exmem_fl} = 3'b111;
          nxt = FLUSH;
        end else if (load_use) begin
          pc_st   = 1'b1;
          ifid_st = 1'b1;
          idex_fl = 1'b1;
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (!hif.mem_ack_i) begin
          {pc_st, ifid_st, idex_st, exmem_st} = 4'hf;
          if (wcnt == TMO) nxt = ERR;
          else             wcnt_nxt = wcnt + 8'd1;
        end else begin
          wcnt_nxt = 8'd0;
          nxt      = RUN;
          if (hif.exmem_branch_i) begin
            {ifid_fl, idex_fl, exmem_fl} = 3'b111;
            nxt = FLUSH;
          end
        end
      end
      FLUSH: nxt = RUN;
      ERR:   {pc_st, ifid_st, idex_st, exmem_st} = 4'hf;
      default: nxt = RUN;
    endcase
  end

  // Outputs are forced low while reset is held, so a request drops the instant rst_n falls.
  assign hif.mem_req_o     = rst_n & mem_req;
  assign hif.pc_stall_o    = rst_n & pc_st;
  assign hif.ifid_stall_o  = rst_n & ifid_st & ~ifid_fl;
  assign hif.idex_stall_o  = rst_n & idex_st & ~idex_fl;
  assign hif.exmem_stall_o = rst_n & exmem_st & ~exmem_fl;
  assign hif.ifid_flush_o  = rst_n & ifid_fl;
  assign hif.idex_flush_o  = rst_n & idex_fl;
  assign hif.exmem_flush_o = rst_n & exmem_fl;
  assign hif.timeout_o     = timeout_q;
  assign hif.hazard_cnt_o  = hcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wcnt      <= 8'd0;
      hcnt      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= nxt;
      wcnt  <= wcnt_nxt;
      if (nxt == ERR) timeout_q <= 1'b1;
      if (pc_st && (hcnt != {CNT_W{1'b1}})) hcnt <= hcnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;

  // Expected control word: {mem_req, pc_st, ifid_st, idex_st, exmem_st, ifid_fl, idex_fl, exmem_fl, timeout}
  localparam logic [8:0] NONE    = 9'b000000000;
  localparam logic [8:0] LU      = 9'b011000100;
  localparam logic [8:0] BR      = 9'b000001110;
  localparam logic [8:0] MW      = 9'b111110000;
  localparam logic [8:0] MREQ    = 9'b100000000;
  localparam logic [8:0] MREQ_BR = 9'b100001110;
  localparam logic [8:0] MREQ_LU = 9'b111000100;
  localparam logic [8:0] ERRV    = 9'b011110001;

  typedef struct packed {
    logic [8:0]       ctl;
    logic [CNT_W-1:0] hcnt;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t q[$];
  logic [CNT_W-1:0] exp_hcnt;
  int vectors;
  int miscompares;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at posedge+1: drive one cycle of inputs, log its expectation, advance to next posedge+1.
  task automatic step(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic br, input logic ma,
                      input logic ack, input logic [8:0] ctl);
    exp_t e;
    hif.idex_memread_i    = mr;
    hif.idex_rd_i         = rd;
    hif.ifid_rs1_i        = rs1;
    hif.ifid_rs2_i        = rs2;
    hif.exmem_branch_i    = br;
    hif.exmem_memaccess_i = ma;
    hif.mem_ack_i         = ack;
    e.ctl  = ctl;
    e.hcnt = exp_hcnt;
    q.push_back(e);
    if (ctl[7]) exp_hcnt = exp_hcnt + CNT_W'(1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [8:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {hif.mem_req_o, hif.pc_stall_o, hif.ifid_stall_o, hif.idex_stall_o,
             hif.exmem_stall_o, hif.ifid_flush_o, hif.idex_flush_o, hif.exmem_flush_o,
             hif.timeout_o};
      vectors++;
      if (act !== e.ctl || hif.hazard_cnt_o !== e.hcnt) begin
        miscompares++;
        $display("FAIL vec%0d @%0t: ctl got %b want %b, hazard_cnt got %0d want %0d",
                 vectors, $time, act, e.ctl, hif.hazard_cnt_o, e.hcnt);
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_hcnt    = '0;
    rst_n       = 1'b0;
    hif.idex_memread_i    = 1'b0;
    hif.idex_rd_i         = 5'd0;
    hif.ifid_rs1_i        = 5'd0;
    hif.ifid_rs2_i        = 5'd0;
    hif.exmem_branch_i    = 1'b0;
    hif.exmem_memaccess_i = 1'b0;
    hif.mem_ack_i         = 1'b0;
    @(posedge clk);
    #1;
    // reset state, including an access request that must stay masked
    step(0, 0, 0, 0, 0, 0, 0, NONE);
    step(0, 0, 0, 0, 1, 1, 0, NONE);
    rst_n = 1'b1;

    // load-use
    step(1, 5, 5, 0, 0, 0, 0, LU);
    step(0, 0, 0, 0, 0, 0, 0, NONE);
    step(1, 0, 0, 0, 0, 0, 0, NONE);
    step(1, 7, 1, 7, 0, 0, 0, LU);
    step(1, 7, 1, 7, 0, 0, 0, LU);
    step(0, 7, 1, 7, 0, 0, 0, NONE);

    // branch beats load-use; FLUSH suppresses load-use
    step(1, 5, 5, 0, 1, 0, 0, BR);
    step(1, 5, 5, 0, 0, 0, 0, NONE);
    step(1, 5, 5, 0, 0, 0, 0, LU);
    step(0, 0, 0, 0, 0, 0, 0, NONE);

    // memory wait, ack on the 4th cycle
    step(0, 0, 0, 0, 0, 1, 0, MW);
    step(0, 0, 0, 0, 0, 1, 0, MW);
    step(0, 0, 0, 0, 0, 1, 0, MW);
    step(0, 0, 0, 0, 0, 1, 1, MREQ);
    step(0, 0, 0, 0, 0, 0, 0, NONE);
    // zero-wait accesses, alone and with branch / load-use
    step(0, 0, 0, 0, 0, 1, 1, MREQ);
    step(0, 0, 0, 0, 1, 1, 1, MREQ_BR);
    step(0, 0, 0, 0, 0, 0, 0, NONE);
    step(1, 5, 5, 0, 0, 1, 1, MREQ_LU);
    step(0, 0, 0, 0, 0, 0, 0, NONE);

    // branch pending throughout a memory wait
    step(0, 0, 0, 0, 1, 1, 0, MW);
    step(0, 0, 0, 0, 1, 1, 0, MW);
    step(0, 0, 0, 0, 1, 1, 0, MW);
    step(0, 0, 0, 0, 1, 1, 1, MREQ_BR);
    step(1, 5, 5, 0, 0, 0, 0, NONE);
    step(0, 0, 0, 0, 0, 0, 0, NONE);

    // async reset in the middle of a wait
    step(0, 0, 0, 0, 0, 1, 0, MW);
    step(0, 0, 0, 0, 0, 1, 0, MW);
    #1;
    rst_n    = 1'b0;
    exp_hcnt = '0;
    begin
      exp_t e;
      e.ctl  = NONE;
      e.hcnt = '0;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 1, 0, NONE);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, NONE);
    step(0, 0, 0, 0, 0, 1, 1, MREQ);

    // timeout: one RUN stall + 15 MEM_WAIT cycles, then ERR forever
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 1, 0, MW);
    step(0, 0, 0, 0, 0, 1, 0, ERRV);
    step(0, 0, 0, 0, 0, 1, 1, ERRV);
    step(0, 0, 0, 0, 1, 0, 0, ERRV);
    step(1, 5, 5, 0, 0, 0, 0, ERRV);
    rst_n    = 1'b0;
    exp_hcnt = '0;
    step(0, 0, 0, 0, 0, 0, 0, NONE);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, NONE);
    step(0, 0, 0, 0, 0, 1, 1, MREQ);
    step(1, 5, 5, 0, 0, 0, 0, LU);
    step(0, 0, 0, 0, 0, 0, 0, NONE);

    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
